// File: rtl/recmeslen_fd.sv
// Receive DLC register for the CAN MAC: collects DLC bits from macfsm strobes and
// converts the finished DLC to a payload byte count (classic clamp, FD table, RTR = 0).
module recmeslen_fd #(
    parameter int DLCW  = 4,
    parameter int SELW  = 3,
    parameter int LENW  = 7,
    parameter int FD_EN = 1,
    parameter int CLMAX = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clr,
    input  logic            activ,
    input  logic [SELW-1:0] setrmlen,
    input  logic            bitval,
    input  logic            rtr,
    input  logic            fdf,
    output logic [DLCW-1:0] rmlb,
    output logic [LENW-1:0] rlen,
    output logic            rlen_vld,
    output logic            dlc_clip,
    output logic [1:0]      state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] CALC    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // Handshake: activ is a level from macfsm; only its rising edge is a write
    // request, qualified by an in-range setrmlen. There is no back-pressure.
    logic            activ_d;
    logic            strobe;
    logic            hit;
    logic [DLCW-1:0] mask;
    logic [DLCW-1:0] rmlb_n;
    logic [DLCW-1:0] mask_n;
    logic [LENW-1:0] dlc_ext;
    logic [LENW-1:0] cl_max;
    logic [3:0]      dlc4;
    logic [LENW-1:0] calc_len;
    logic            calc_clip;

    assign strobe = activ & ~activ_d;

    // Index k maps to bit DLCW-k so the first received bit lands in the MSB.
    always_comb begin
        rmlb_n = rmlb;
        mask_n = mask;
        hit    = 1'b0;
        for (int k = 1; k <= DLCW; k++) begin
            if (strobe && (state == IDLE || state == COLLECT) && setrmlen == SELW'(k)) begin
                rmlb_n[DLCW-k] = bitval;
                mask_n[DLCW-k] = 1'b1;
                hit            = 1'b1;
            end
        end
    end

    always_comb begin
        dlc_ext   = LENW'(rmlb);
        cl_max    = LENW'(CLMAX);
        dlc4      = 4'(rmlb);
        calc_len  = dlc_ext;
        calc_clip = 1'b0;
        if (rtr) begin
            calc_len = '0;
        end else if (FD_EN != 0 && DLCW == 4 && fdf) begin
            case (dlc4)
                4'd9:    calc_len = LENW'(12);
                4'd10:   calc_len = LENW'(16);
                4'd11:   calc_len = LENW'(20);
                4'd12:   calc_len = LENW'(24);
                4'd13:   calc_len = LENW'(32);
                4'd14:   calc_len = LENW'(48);
                4'd15:   calc_len = LENW'(64);
                default: calc_len = dlc_ext;
            endcase
        end else if (dlc_ext > cl_max) begin
            calc_len  = cl_max;
            calc_clip = 1'b1;
        end
    end

    // Clearing activ_d lets a level held through clr/reset strobe once afterwards.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            activ_d  <= 1'b0;
            rmlb     <= '0;
            mask     <= '0;
            rlen     <= '0;
            rlen_vld <= 1'b0;
            dlc_clip <= 1'b0;
            state    <= IDLE;
        end else begin
            activ_d <= activ;
            case (state)
                IDLE, COLLECT: begin
                    if (hit) begin
                        rmlb  <= rmlb_n;
                        mask  <= mask_n;
                        state <= (&mask_n) ? CALC : COLLECT;
                    end
                end
                CALC: begin
                    rlen     <= calc_len;
                    dlc_clip <= calc_clip;
                    rlen_vld <= 1'b1;
                    state    <= DONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_recmeslen_fd.sv
// Bench for recmeslen_fd: directed frame table, hand-written corner sequences and
// randomized cycles compared against a frame-level reference model.
module tb_recmeslen_fd;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       activ = 1'b0;
    logic [2:0] setrmlen = 3'd0;
    logic       bitval = 1'b0;
    logic       rtr = 1'b0;
    logic       fdf = 1'b0;
    logic [3:0] rmlb;
    logic [6:0] rlen;
    logic       rlen_vld;
    logic       dlc_clip;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    recmeslen_fd dut (
        .clock(clock), .reset(reset), .clr(clr), .activ(activ),
        .setrmlen(setrmlen), .bitval(bitval), .rtr(rtr), .fdf(fdf),
        .rmlb(rmlb), .rlen(rlen), .rlen_vld(rlen_vld), .dlc_clip(dlc_clip),
        .state(state)
    );

    always #5 clock = ~clock;

    // Reference model: what the frame register should hold after each edge.
    int         fd_tab[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};
    logic [3:0] m_rmlb;
    logic [3:0] m_mask;
    logic       m_calc;
    logic       m_done;
    logic       m_prev;
    int         m_rlen;
    logic       m_vld;
    logic       m_clip;

    task automatic model_step();
        int idx;
        idx = int'(setrmlen);
        if (reset || clr) begin
            m_rmlb = 4'h0; m_mask = 4'h0; m_calc = 1'b0; m_done = 1'b0;
            m_prev = 1'b0; m_rlen = 0; m_vld = 1'b0; m_clip = 1'b0;
        end else begin
            if (m_calc) begin
                if (rtr) begin
                    m_rlen = 0; m_clip = 1'b0;
                end else if (fdf) begin
                    m_rlen = fd_tab[m_rmlb]; m_clip = 1'b0;
                end else begin
                    m_rlen = (int'(m_rmlb) > 8) ? 8 : int'(m_rmlb);
                    m_clip = (int'(m_rmlb) > 8);
                end
                m_vld  = 1'b1;
                m_calc = 1'b0;
                m_done = 1'b1;
            end else if (!m_done && activ && !m_prev && idx >= 1 && idx <= 4) begin
                m_rmlb[4-idx] = bitval;
                m_mask[4-idx] = 1'b1;
                if (m_mask == 4'hF) m_calc = 1'b1;
            end
            m_prev = activ;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, ".rmlb"}, 32'(rmlb), 32'h0);
        check({name, ".rlen"}, 32'(rlen), 32'h0);
        check({name, ".vld"}, 32'(rlen_vld), 32'h0);
        check({name, ".clip"}, 32'(dlc_clip), 32'h0);
        check({name, ".state"}, 32'(state), 32'h0);
    endtask

    task automatic do_clr();
        clr = 1'b1; activ = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic strobe(input int idx, input logic b);
        activ = 1'b1; setrmlen = 3'(idx); bitval = b;
        tick();
        activ = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [3:0] dlc;
        logic       rtr;
        logic       fdf;
        logic [6:0] exp_len;
        logic       exp_clip;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'hA, 1'b0, 1'b0, 7'd8,  1'b1};
        vecs[1] = '{4'hD, 1'b0, 1'b1, 7'd32, 1'b0};
        vecs[2] = '{4'hF, 1'b0, 1'b1, 7'd64, 1'b0};
        vecs[3] = '{4'h5, 1'b1, 1'b0, 7'd0,  1'b0};
        vecs[4] = '{4'h3, 1'b0, 1'b0, 7'd3,  1'b0};
        vecs[5] = '{4'h9, 1'b0, 1'b1, 7'd12, 1'b0};
        vecs[6] = '{4'hC, 1'b0, 1'b0, 7'd8,  1'b1};
        vecs[7] = '{4'h8, 1'b0, 1'b1, 7'd8,  1'b0};
        vecs[8] = '{4'hF, 1'b1, 1'b1, 7'd0,  1'b0};

        // Reset with activ held high, then exactly one strobe once reset drops.
        reset = 1'b1; activ = 1'b1; setrmlen = 3'd1; bitval = 1'b1;
        tick(); tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check("post_reset_strobe", 32'(rmlb), 32'h8);
        setrmlen = 3'd2;
        tick();
        check("held_level_no_write", 32'(rmlb), 32'h8);
        activ = 1'b0;

        // Table of complete frames, with latency checked at the final write.
        foreach (vecs[i]) begin
            do_clr();
            rtr = vecs[i].rtr; fdf = vecs[i].fdf;
            for (int k = 1; k <= 4; k++) begin
                activ = 1'b1; setrmlen = 3'(k); bitval = vecs[i].dlc[4-k];
                tick();
                activ = 1'b0;
                if (k < 4) tick();
            end
            check($sformatf("vec%0d.rmlb", i), 32'(rmlb), 32'(vecs[i].dlc));
            check($sformatf("vec%0d.vld_early", i), 32'(rlen_vld), 32'h0);
            tick();
            check($sformatf("vec%0d.vld", i), 32'(rlen_vld), 32'h1);
            check($sformatf("vec%0d.rlen", i), 32'(rlen), 32'(vecs[i].exp_len));
            check($sformatf("vec%0d.clip", i), 32'(dlc_clip), 32'(vecs[i].exp_clip));
        end
        rtr = 1'b0; fdf = 1'b0;

        // Index corner cases: out-of-range indices, overwrite, long held level.
        do_clr();
        strobe(0, 1'b1);
        strobe(5, 1'b1);
        check("idx_out_of_range", 32'(rmlb), 32'h0);
        check("idx_out_of_range.state", 32'(state), 32'h0);
        strobe(1, 1'b0);
        strobe(2, 1'b1);
        strobe(2, 1'b0);
        check("idx2_overwrite", 32'(rmlb), 32'h0);
        activ = 1'b1; setrmlen = 3'd3; bitval = 1'b1;
        tick();
        setrmlen = 3'd4;
        for (int c = 0; c < 4; c++) tick();
        activ = 1'b0;
        tick();
        check("held_5_cycles", 32'(rmlb), 32'h2);
        check("no_calc_before_all", 32'(state), 32'h1);
        check("no_vld_before_all", 32'(rlen_vld), 32'h0);
        strobe(4, 1'b1);
        check("corner_frame.vld", 32'(rlen_vld), 32'h1);
        check("corner_frame.rlen", 32'(rlen), 32'h3);

        // clr mid-collection, clr with a simultaneous strobe, strobes in DONE.
        do_clr();
        strobe(1, 1'b1);
        strobe(2, 1'b1);
        do_clr();
        check_zero("clr_mid");
        activ = 1'b1; setrmlen = 3'd1; bitval = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        check_zero("clr_with_strobe");
        tick();
        check("strobe_after_clr", 32'(rmlb), 32'h8);
        activ = 1'b0;
        tick();
        strobe(2, 1'b0);
        strobe(3, 1'b1);
        strobe(4, 1'b1);
        check("done.rmlb", 32'(rmlb), 32'hB);
        check("done.rlen", 32'(rlen), 32'h8);
        strobe(1, 1'b0);
        strobe(4, 1'b0);
        check("done_frozen.rmlb", 32'(rmlb), 32'hB);
        check("done_frozen.vld", 32'(rlen_vld), 32'h1);
        do_clr();
        check_zero("clr_in_done");

        // Randomized cycles against the reference model.
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 499) == 0);
            clr      = ($urandom_range(0, 59) == 0);
            activ    = 1'($urandom_range(0, 1));
            setrmlen = 3'($urandom_range(0, 7));
            bitval   = 1'($urandom_range(0, 1));
            rtr      = ($urandom_range(0, 3) == 0);
            fdf      = 1'($urandom_range(0, 1));
            tick();
            check("rand.rmlb", 32'(rmlb), 32'(m_rmlb));
            check("rand.rlen", 32'(rlen), 32'(m_rlen));
            check("rand.vld", 32'(rlen_vld), 32'(m_vld));
            check("rand.clip", 32'(dlc_clip), 32'(m_clip));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/recmeslen_fd.md
Name: recmeslen_fd

Overview:
- Reception data-length register for the CAN MAC receive path.
- Assembles the DLC field bit-by-bit from macfsm strobes and converts it to the actual payload length in bytes.
- Classic CAN: DLC is clamped to 8. CAN FD: the 9..15 table applies. RTR frames always yield 0.
- Sits between macfsm and the receive buffer/ack logic. Adds per-bit values, fill tracking, a valid flag and FD decoding.

Parameters:
- DLCW, 4, DLC field width in bits (1..4).
- SELW, 3, width of the bit-index select input.
- LENW, 7, width of the byte-length output (must hold 64).
- FD_EN, 1, 1 = enable the FD length table when fdf=1; 0 = classic decoding only.
- CLMAX, 8, classic-mode maximum byte count.

Ports:
- clock, in, 1, system clock; all logic on the rising edge.
- reset, in, 1, synchronous active-high reset.
- clr, in, 1, synchronous frame clear (macfsm resrmlen) at start of a new frame.
- activ, in, 1, bit strobe level (macfsm actvrmlen); acts on its rising edge only.
- setrmlen, in, SELW, bit index 1..DLCW; index k writes rmlb[DLCW-k] (first received bit = MSB).
- bitval, in, 1, DLC bit value written on a strobe.
- rtr, in, 1, remote frame flag; sampled in CALC.
- fdf, in, 1, FD frame flag; sampled in CALC.
- rmlb, out, DLCW, raw assembled DLC.
- rlen, out, LENW, payload length in bytes.
- rlen_vld, out, 1, rlen valid.
- dlc_clip, out, 1, classic frame with DLC > CLMAX (rlen clamped).

Behaviour:
Edge detection:
- Register activ_d. Strobe = activ & ~activ_d.
- reset or clr force activ_d=0, so an activ held high through clr produces one strobe on the next cycle.
- A level held high longer than one cycle produces no further strobes.
- A valid strobe requires 1 <= setrmlen <= DLCW. Index 0 or index > DLCW is ignored: no write, no state change.

Reset and clear:
- reset (priority over everything) sets: rmlb=0, rlen=0, rlen_vld=0, dlc_clip=0, fill mask=0, state=IDLE.
- clr has the same effect as reset. clr wins over a simultaneous strobe, and over clr mid-collection or in DONE.

States:
- IDLE: a valid strobe writes the bit, sets its fill-mask bit, and goes to COLLECT. If DLCW=1, it goes directly to CALC.
- COLLECT: a valid strobe writes the bit and sets its mask bit. A repeated index overwrites the value; the mask is unchanged. When the mask becomes all ones (on the edge of the write), go to CALC.
- CALC (one cycle): samples rtr and fdf, then registers:
  - rtr=1: rlen=0, dlc_clip=0.
  - FD (FD_EN=1, fdf=1, DLCW=4): DLC 0..8 gives the same value; 9→12, 10→16, 11→20, 12→24, 13→32, 14→48, 15→64; dlc_clip=0.
  - otherwise: rlen=min(DLC,CLMAX), dlc_clip=(DLC>CLMAX).
  - Then rlen_vld<=1 and go to DONE.
- DONE: outputs hold. Strobes are ignored and rmlb is frozen. Leave only via clr or reset.

Timing and widths:
- Latency: the rlen_vld rising edge comes exactly 1 clock after the edge that writes the final DLC bit.
- rmlb is visible the cycle after each write.
- rlen is zero-extended to LENW. No arithmetic wraps.

Test Plan:
- Reset with activ=1 held → all outputs 0. After reset drops, exactly one strobe is taken for the current setrmlen.
- Classic: fdf=0, rtr=0; strobes idx1..4 with bits 1,0,1,0 → rmlb=4'hA, rlen=8, dlc_clip=1, rlen_vld high 1 cycle after the idx4 write.
- FD: fdf=1; bits 1,1,0,1 → rmlb=4'hD, rlen=32, dlc_clip=0. Repeat with 4'hF → rlen=64.
- RTR: rtr=1, DLC=4'h5 → rmlb=5, rlen=0, rlen_vld=1.
- Index edge cases: idx0, idx5, repeated idx2 with a new value, and activ held high 5 cycles → only valid rising edges write. The last idx2 value wins. CALC is entered only after all 4 indices are written.
- clr asserted mid-collection (after 2 bits) and in the same cycle as a strobe, and strobe after DONE → state IDLE, all outputs 0, simultaneous strobe discarded, DONE-state strobes do not alter rmlb.
